// File: rtl/host_packet_router_if.sv
// Host-side channel bus bundle: host link byte streams plus the per-channel
// master/slave signals. The router drives through the master modport.
interface host_packet_router_if #(
  parameter int N_CH = 5
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        master_data;
  logic [N_CH-1:0]   valid_bus;
  logic [N_CH-1:0]   rdreq_bus;
  logic [N_CH-1:0]   have_msg_bus;
  logic [8*N_CH-1:0] len_bus;
  logic [8*N_CH-1:0] slave_data_bus;
  logic              rx_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, have_msg_bus, len_bus, slave_data_bus,
    output tx_data, tx_valid, master_data, valid_bus, rdreq_bus, rx_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, have_msg_bus, len_bus, slave_data_bus,
    input  tx_data, tx_valid, master_data, valid_bus, rdreq_bus, rx_err
  );
endinterface

// File: rtl/host_packet_router.sv
// Host link framer/deframer: RX dispatches framed payload to one channel,
// TX round-robin polls channel FIFOs and frames their messages to the host.
//
// state       | meaning
// RX_HUNT     | waiting for SYNC
// RX_ADDR     | next byte is channel address
// RX_LEN      | next byte is payload length
// RX_DATA     | forwarding payload bytes
// RX_CHK      | next byte is checksum
// TX_POLL     | searching channels after the round-robin pointer
// TX_HDR_SYNC | presenting SYNC
// TX_HDR_ADDR | presenting channel index
// TX_HDR_LEN  | presenting latched length
// TX_RD       | one-cycle read request to channel FIFO
// TX_LATCH    | capturing FIFO byte
// TX_SEND     | presenting payload byte
// TX_CHK      | presenting checksum
module host_packet_router #(
  parameter int         N_CH    = 5,
  parameter logic [7:0] SYNC    = 8'h55,
  parameter int         TIMEOUT = 1000000
) (
  input logic                  sys_clk,
  input logic                  n_rst,
  host_packet_router_if.master bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {RX_HUNT, RX_ADDR, RX_LEN, RX_DATA, RX_CHK} rx_state_t;
  typedef enum logic [2:0] {
    TX_POLL, TX_HDR_SYNC, TX_HDR_ADDR, TX_HDR_LEN, TX_RD, TX_LATCH, TX_SEND, TX_CHK
  } tx_state_t;

  rx_state_t        rx_state;
  logic [7:0]       rx_addr;
  logic [7:0]       rx_cnt;
  logic [7:0]       rx_xor;
  logic [GAP_W-1:0] gap_cnt;
  logic [N_CH-1:0]  addr_hot;

  tx_state_t        tx_state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  tx_ch;
  logic [7:0]       tx_cnt;
  logic [7:0]       tx_xor;
  logic [N_CH-1:0]  ch_hot;

  logic [7:0]       len_arr [N_CH];
  logic [7:0]       slv_arr [N_CH];
  logic             poll_hit;
  logic [CH_W-1:0]  poll_ch;
  logic [CH_W-1:0]  cand;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    assign len_arr[k]  = bus.len_bus[8*k +: 8];
    assign slv_arr[k]  = bus.slave_data_bus[8*k +: 8];
    assign addr_hot[k] = (rx_addr == 8'(k));
    assign ch_hot[k]   = (tx_ch == CH_W'(k));
  end

  // Gap timer is a down-counter reloaded on every byte; expiry aborts the frame.
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_state        <= RX_HUNT;
      rx_addr         <= '0;
      rx_cnt          <= '0;
      rx_xor          <= '0;
      gap_cnt         <= GAP_LOAD;
      bus.master_data <= '0;
      bus.valid_bus   <= '0;
      bus.rx_err      <= 1'b0;
    end else begin
      bus.valid_bus <= '0;
      bus.rx_err    <= 1'b0;
      if (bus.rx_valid) begin
        gap_cnt <= GAP_LOAD;
        case (rx_state)
          RX_HUNT: if (bus.rx_data == SYNC) rx_state <= RX_ADDR;
          RX_ADDR: begin
            rx_addr  <= bus.rx_data;
            rx_xor   <= bus.rx_data;
            rx_state <= RX_LEN;
          end
          RX_LEN: begin
            if (bus.rx_data == 8'd0) begin
              bus.rx_err <= 1'b1;
              rx_state   <= RX_HUNT;
            end else begin
              rx_cnt   <= bus.rx_data;
              rx_xor   <= rx_xor ^ bus.rx_data;
              rx_state <= RX_DATA;
            end
          end
          RX_DATA: begin
            bus.master_data <= bus.rx_data;
            bus.valid_bus   <= addr_hot;
            rx_xor          <= rx_xor ^ bus.rx_data;
            rx_cnt          <= rx_cnt - 8'd1;
            if (rx_cnt == 8'd1) rx_state <= RX_CHK;
          end
          RX_CHK: begin
            bus.rx_err <= (bus.rx_data != rx_xor) || (addr_hot == '0);
            rx_state   <= RX_HUNT;
          end
          default: rx_state <= RX_HUNT;
        endcase
      end else if (rx_state != RX_HUNT) begin
        if (gap_cnt == '0) begin
          bus.rx_err <= 1'b1;
          rx_state   <= RX_HUNT;
          gap_cnt    <= GAP_LOAD;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end else begin
        gap_cnt <= GAP_LOAD;
      end
    end
  end

  always_comb begin
    poll_hit = 1'b0;
    poll_ch  = '0;
    cand     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (!poll_hit && bus.have_msg_bus[cand] && (len_arr[cand] != 8'd0)) begin
        poll_hit = 1'b1;
        poll_ch  = cand;
      end
    end
  end

  // tx_valid is high in every HDR/SEND/CHK state, so tx_ready alone marks the handshake.
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state      <= TX_POLL;
      rr_ptr        <= '0;
      tx_ch         <= '0;
      tx_cnt        <= '0;
      tx_xor        <= '0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
      bus.rdreq_bus <= '0;
    end else begin
      case (tx_state)
        TX_POLL: begin
          if (poll_hit) begin
            tx_ch        <= poll_ch;
            tx_cnt       <= len_arr[poll_ch];
            tx_xor       <= 8'(poll_ch) ^ len_arr[poll_ch];
            bus.tx_data  <= SYNC;
            bus.tx_valid <= 1'b1;
            tx_state     <= TX_HDR_SYNC;
          end
        end
        TX_HDR_SYNC: if (bus.tx_ready) begin
          bus.tx_data <= 8'(tx_ch);
          tx_state    <= TX_HDR_ADDR;
        end
        TX_HDR_ADDR: if (bus.tx_ready) begin
          bus.tx_data <= tx_cnt;
          tx_state    <= TX_HDR_LEN;
        end
        TX_HDR_LEN: if (bus.tx_ready) begin
          bus.tx_valid  <= 1'b0;
          bus.rdreq_bus <= ch_hot;
          tx_state      <= TX_RD;
        end
        TX_RD: begin
          bus.rdreq_bus <= '0;
          tx_state      <= TX_LATCH;
        end
        TX_LATCH: begin
          bus.tx_data  <= slv_arr[tx_ch];
          tx_xor       <= tx_xor ^ slv_arr[tx_ch];
          bus.tx_valid <= 1'b1;
          tx_state     <= TX_SEND;
        end
        TX_SEND: if (bus.tx_ready) begin
          tx_cnt <= tx_cnt - 8'd1;
          if (tx_cnt == 8'd1) begin
            bus.tx_data <= tx_xor;
            tx_state    <= TX_CHK;
          end else begin
            bus.tx_valid  <= 1'b0;
            bus.rdreq_bus <= ch_hot;
            tx_state      <= TX_RD;
          end
        end
        TX_CHK: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          rr_ptr       <= tx_ch;
          tx_state     <= TX_POLL;
        end
        default: tx_state <= TX_POLL;
      endcase
    end
  end
endmodule

// File: tb/tb_host_packet_router.sv
// Self-checking bench: frame-level model predicts channel strobes, rx_err pulses
// and the host TX byte stream; a per-cycle compare process checks the DUT.
module tb_host_packet_router;
  localparam int         N_CH    = 5;
  localparam logic [7:0] SYNC    = 8'h55;
  localparam int         TIMEOUT = 16;

  logic sys_clk = 1'b0;
  logic n_rst   = 1'b0;

  host_packet_router_if #(.N_CH(N_CH)) bus();

  host_packet_router #(.N_CH(N_CH), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk),
    .n_rst  (n_rst),
    .bus    (bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] d;
  } vev_t;

  vev_t            exp_v[$];
  int              exp_err[$];
  logic [7:0]      exp_tx[$];
  logic [7:0]      fifo [N_CH][$];
  logic [N_CH-1:0] hm_force = '0;
  logic [7:0]      rx_pl[$];
  logic [7:0]      tx_pl[$];
  logic [7:0]      rx_log[$];
  logic [7:0]      tx_log[$];
  int              rdreq_cnt [N_CH];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic            chk_on = 1'b0;
  int              rdy_mode = 1;
  logic            prev_stall = 1'b0;
  logic [7:0]      prev_data = '0;
  logic            err_exp;
  logic [N_CH-1:0] rd_seen;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic refresh_bus();
    for (int k = 0; k < N_CH; k++) begin
      bus.have_msg_bus[k]     = (fifo[k].size() != 0) || hm_force[k];
      bus.len_bus[8*k +: 8]   = 8'(fifo[k].size());
    end
  endtask

  // Channel FIFO model: non-show-ahead, data appears the cycle after rdreq.
  always @(posedge sys_clk) begin
    rd_seen = bus.rdreq_bus;
    #1;
    for (int k = 0; k < N_CH; k++)
      if (rd_seen[k] && fifo[k].size() != 0) bus.slave_data_bus[8*k +: 8] = fifo[k].pop_front();
    refresh_bus();
  end

  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      case (rdy_mode)
        0:       bus.tx_ready = ~bus.tx_ready;
        1:       bus.tx_ready = 1'b1;
        2:       bus.tx_ready = 1'b0;
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge sys_clk) begin
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else if (chk_on) begin
      if (exp_v.size() != 0 && exp_v[0].cyc == cyc) begin
        check("valid_bus", 32'(bus.valid_bus), 32'(1) << exp_v[0].ch);
        check("master_data", 32'(bus.master_data), 32'(exp_v[0].d));
        rx_log.push_back(bus.master_data);
        void'(exp_v.pop_front());
      end else begin
        check("valid_bus idle", 32'(bus.valid_bus), 32'd0);
      end
      err_exp = (exp_err.size() != 0 && exp_err[0] == cyc);
      if (err_exp) void'(exp_err.pop_front());
      check("rx_err", 32'(bus.rx_err), 32'(err_exp));
      if (prev_stall) begin
        check("tx_valid held", 32'(bus.tx_valid), 32'd1);
        check("tx_data held", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_log.push_back(bus.tx_data);
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx extra byte at cycle %0d: got %0h, expected none", cyc, bus.tx_data);
        end else begin
          check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.rdreq_bus != '0) begin
        check("rdreq while tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rdreq onehot", 32'($onehot(bus.rdreq_bus)), 32'd1);
        for (int k = 0; k < N_CH; k++) if (bus.rdreq_bus[k]) rdreq_cnt[k]++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge sys_clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    c = cyc + 1;
    @(posedge sys_clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] addr, input logic bad, input logic [7:0] chkv);
    logic [7:0] x;
    int c;
    x = addr ^ 8'(rx_pl.size());
    foreach (rx_pl[i]) x ^= rx_pl[i];
    send_byte(SYNC, c);
    send_byte(addr, c);
    send_byte(8'(rx_pl.size()), c);
    foreach (rx_pl[i]) begin
      send_byte(rx_pl[i], c);
      if (addr < N_CH) exp_v.push_back('{c, int'(addr), rx_pl[i]});
    end
    send_byte(bad ? chkv : x, c);
    if (addr >= N_CH || (bad && chkv != x)) exp_err.push_back(c);
  endtask

  task automatic load_ch(input int ch);
    logic [7:0] x;
    x = 8'(ch) ^ 8'(tx_pl.size());
    exp_tx.push_back(SYNC);
    exp_tx.push_back(8'(ch));
    exp_tx.push_back(8'(tx_pl.size()));
    foreach (tx_pl[i]) begin
      fifo[ch].push_back(tx_pl[i]);
      exp_tx.push_back(tx_pl[i]);
      x ^= tx_pl[i];
    end
    exp_tx.push_back(x);
    refresh_bus();
  endtask

  task automatic wait_tx(input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    check("tx stream drained", 32'(exp_tx.size()), 32'd0);
    exp_tx.delete();
    repeat (4) @(posedge sys_clk);
  endtask

  task automatic check_outputs_zero();
    check("rst master_data", 32'(bus.master_data), 32'd0);
    check("rst valid_bus", 32'(bus.valid_bus), 32'd0);
    check("rst rdreq_bus", 32'(bus.rdreq_bus), 32'd0);
    check("rst tx_data", 32'(bus.tx_data), 32'd0);
    check("rst tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst rx_err", 32'(bus.rx_err), 32'd0);
  endtask

  logic [7:0] lit_rx [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] lit_tx [6] = '{8'h55, 8'h04, 8'h02, 8'h3C, 8'h5A, 8'h60};

  initial begin
    int c;
    bus.rx_valid       = 1'b0;
    bus.rx_data        = '0;
    bus.have_msg_bus   = '0;
    bus.len_bus        = '0;
    bus.slave_data_bus = '0;
    foreach (rdreq_cnt[k]) rdreq_cnt[k] = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs_zero();
    @(posedge sys_clk);
    #1;
    n_rst  = 1'b1;
    chk_on = 1'b1;

    // Good frame to channel 1: XOR 01^03^11^22^33 = 02.
    rx_pl = '{8'h11, 8'h22, 8'h33};
    rx_log.delete();
    rx_frame(8'h01, 1'b1, 8'h02);
    repeat (2) @(posedge sys_clk);
    check("rx pulse count", 32'(rx_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("rx byte literal", 32'((i < rx_log.size()) ? rx_log[i] : 8'h00), 32'(lit_rx[i]));

    rx_frame(8'h01, 1'b1, 8'h00);
    rx_pl = '{8'hAA, 8'hBB};
    rx_frame(8'h07, 1'b0, 8'h00);
    rx_pl = '{SYNC, 8'h01};
    rx_frame(8'h03, 1'b0, 8'h00);

    send_byte(SYNC, c);
    send_byte(8'h02, c);
    send_byte(8'h00, c);
    exp_err.push_back(c);

    send_byte(SYNC, c);
    send_byte(8'h00, c);
    send_byte(8'h04, c);
    exp_err.push_back(c + TIMEOUT);
    repeat (TIMEOUT + 4) @(posedge sys_clk);
    rx_pl = '{8'h5A};
    rx_frame(8'h00, 1'b0, 8'h00);

    // TX channel 4 with tx_ready toggling.
    rdy_mode = 0;
    tx_log.delete();
    foreach (rdreq_cnt[k]) rdreq_cnt[k] = 0;
    @(posedge sys_clk);
    #1;
    tx_pl = '{8'h3C, 8'h5A};
    load_ch(4);
    wait_tx(200);
    check("rdreq[4] pulses", 32'(rdreq_cnt[4]), 32'd2);
    check("tx frame length", 32'(tx_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check("tx byte literal", 32'((i < tx_log.size()) ? tx_log[i] : 8'h00), 32'(lit_tx[i]));

    // Serve channel 2 alone so the pointer lands on 2.
    rdy_mode = 1;
    @(posedge sys_clk);
    #1;
    tx_pl = '{8'hA1};
    load_ch(2);
    wait_tx(200);

    // Channels 2 and 4 pending, channel 3 flags a message with len 0; RX runs alongside.
    rdy_mode = 3;
    foreach (rdreq_cnt[k]) rdreq_cnt[k] = 0;
    fork
      begin
        @(posedge sys_clk);
        #1;
        hm_force[3] = 1'b1;
        tx_pl = '{8'hC4, 8'hD5, 8'hE6};
        load_ch(4);
        tx_pl = '{8'h17, 8'h28};
        load_ch(2);
        wait_tx(400);
      end
      begin
        rx_pl = '{8'h09, 8'h08, 8'h07, 8'h06};
        rx_frame(8'h02, 1'b0, 8'h00);
      end
    join
    check("rdreq[3] skipped", 32'(rdreq_cnt[3]), 32'd0);
    check("rdreq[4] pulses", 32'(rdreq_cnt[4]), 32'd3);
    check("rdreq[2] pulses", 32'(rdreq_cnt[2]), 32'd2);
    hm_force[3] = 1'b0;
    refresh_bus();

    // Reset with a partial RX frame and a stalled TX frame in flight.
    rdy_mode = 2;
    @(posedge sys_clk);
    #1;
    tx_pl = '{8'h77};
    load_ch(1);
    send_byte(SYNC, c);
    send_byte(8'h01, c);
    repeat (3) @(posedge sys_clk);
    #1;
    n_rst = 1'b0;
    fifo[1].delete();
    exp_tx.delete();
    refresh_bus();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs_zero();
    @(posedge sys_clk);
    #1;
    n_rst    = 1'b1;
    rdy_mode = 1;
    rx_pl = '{8'h42};
    rx_frame(8'h04, 1'b0, 8'h00);

    repeat (6) @(posedge sys_clk);
    check("leftover strobes", 32'(exp_v.size()), 32'd0);
    check("leftover rx_err", 32'(exp_err.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
